// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if
//   Bundles the two sides of the sequential multiplier:
//   - core side: start / operands in, busy / done / product out
//   - ALU side : alu_a / alu_b / alu_op out, alu_result / alu_carry in
//   - dbg_state: current FSM state, exported for checkers and debug
//
// Handshake: a request is accepted only when start is high at a rising
// clock edge while the controller is idle; there is no queueing. After
// acceptance busy stays high for 2*WIDTH cycles, then done pulses for
// exactly one cycle with product valid. product holds its value until the
// next completed multiply.
//
// Modports:
//   master - the core / environment that drives start and the ALU result
//   slave  - the multiply controller
interface alu_mul_seq_if #(
    parameter int WIDTH = 8
) ();
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [2:0]         alu_op;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;
    logic [1:0]         dbg_state;

    modport master (
        output start, multiplicand, multiplier, alu_result, alu_carry,
        input  busy, done, product, alu_a, alu_b, alu_op, dbg_state
    );

    modport slave (
        input  start, multiplicand, multiplier, alu_result, alu_carry,
        output busy, done, product, alu_a, alu_b, alu_op, dbg_state
    );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
//   Shift-and-add unsigned multiplier that borrows the shared combinational
//   ALU for its accumulate step. Each of the WIDTH multiplier bits costs one
//   ADD cycle (ALU adds m into hi when lo[0] is set) and one SHIFT cycle
//   ({c,hi,lo} shifted right by one), so latency is always 2*WIDTH cycles.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset; aborts any multiply in flight
//   bus - alu_mul_seq_if.slave (core handshake, ALU operands/result, debug)
module alu_mul_seq #(
    parameter int         WIDTH  = 8,
    parameter logic [2:0] OP_ADD = 3'b000
) (
    input  logic          clk,
    input  logic          rst,
    alu_mul_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               c_q, c_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = bus.multiplicand;
                    lo_d    = bus.multiplier;
                    hi_d    = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (lo_q[0]) begin
                    hi_d = bus.alu_result;
                    c_d  = bus.alu_carry;
                end else begin
                    c_d  = 1'b0;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                // The carry of the accumulate drops into the top of hi, so the
                // full (WIDTH+1)-bit partial sum is never truncated.
                c_d   = 1'b0;
                hi_d  = {c_q, hi_q[WIDTH-1:1]};
                lo_d  = {hi_q[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(WIDTH - 1)) begin
                    // Register the product on DONE entry so it is already
                    // valid during the done pulse.
                    product_d = {hi_d, lo_d};
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d   = ADD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    // ALU operands decode straight from the state register; outside ADD the
    // ALU sees zeros so it is free for other users.
    assign bus.alu_a     = (state_q == ADD) ? hi_q : '0;
    assign bus.alu_b     = (state_q == ADD) ? m_q  : '0;
    assign bus.alu_op    = OP_ADD;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.product   = product_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mul_seq_if #(.WIDTH(W)) bus ();

  alu_mul_seq #(.WIDTH(W), .OP_ADD(3'b000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALU: 8-bit add with carry-out for opcode 000.
  always_comb begin
    {bus.alu_carry, bus.alu_result} = (bus.alu_op == 3'b000) ?
      ({1'b0, bus.alu_a} + {1'b0, bus.alu_b}) : 9'd0;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; start is sampled at the following rising edge.
  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q, input bit hold);
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    exp_q.push_back({8'd0, m} * {8'd0, q});
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Follows one accepted multiply from the edge after its start sample.
  // Before ADD step i, hi must equal (M * (Q mod 2^i)) >> i.
  task automatic track(input logic [W-1:0] m, input logic [W-1:0] q, input bit scramble);
    logic [2*W-1:0] exp;
    logic [2*W-1:0] partial;
    int i;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      check("busy_during_op", 32'(bus.busy), 32'd1);
      check("done_during_op", 32'(bus.done), 32'd0);
      check("alu_op", 32'(bus.alu_op), 32'd0);
      if (j % 2 == 0) begin
        i = j / 2;
        partial = {8'd0, m} * ({8'd0, q} & ((16'd1 << i) - 16'd1));
        check("alu_a_add", 32'(bus.alu_a), 32'(partial >> i));
        check("alu_b_add", 32'(bus.alu_b), 32'(m));
      end else begin
        check("alu_a_shift", 32'(bus.alu_a), 32'd0);
        check("alu_b_shift", 32'(bus.alu_b), 32'd0);
      end
      if (scramble) begin
        bus.multiplicand = W'($urandom_range(0, 255));
        bus.multiplier   = W'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("product_at_done", 32'(bus.product), 32'(exp));
    @(negedge clk);
    check("done_after", 32'(bus.done), 32'd0);
    check("busy_after", 32'(bus.busy), 32'd0);
    check("product_held", 32'(bus.product), 32'(exp));
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{m: 8'd10,  q: 8'd5,   exp: 16'd50};
    vecs[1] = '{m: 8'd255, q: 8'd255, exp: 16'd65025};
    vecs[2] = '{m: 8'd0,   q: 8'd200, exp: 16'd0};
    vecs[3] = '{m: 8'd173, q: 8'd0,   exp: 16'd0};
    vecs[4] = '{m: 8'd127, q: 8'd1,   exp: 16'd127};
    vecs[5] = '{m: 8'd1,   q: 8'd128, exp: 16'd128};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int v = 0; v < 6; v++) begin
      issue(vecs[v].m, vecs[v].q, 1'b0);
      check("table_model_agrees", 32'(exp_q[0]), 32'(vecs[v].exp));
      track(vecs[v].m, vecs[v].q, 1'b0);
    end

    // Random operands against the arithmetic model, random idle gaps
    for (int r = 0; r < 20; r++) begin
      logic [W-1:0] rm, rq;
      rm = W'($urandom_range(0, 255));
      rq = W'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(rm, rq, 1'b0);
      track(rm, rq, 1'b1);
    end

    // start held high: operand changes while busy are ignored, start in DONE
    // is ignored, and the next multiply starts from the following IDLE cycle.
    issue(8'd3, 8'd7, 1'b1);
    track(8'd3, 8'd7, 1'b1);
    issue(8'd9, 8'd11, 1'b0);
    track(8'd9, 8'd11, 1'b0);

    // Reset in the middle of a 200*3 multiply
    issue(8'd200, 8'd3, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    check("abort_alu_a", 32'(bus.alu_a), 32'd0);
    check("abort_alu_b", 32'(bus.alu_b), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(8'd12, 8'd12, 1'b0);
    track(8'd12, 8'd12, 1'b0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
